// File: rtl/libv_deque.sv
// Bounded double-ended queue on a circular buffer with front/back pointers.
// One command per cycle; pops answer on a registered response port one cycle later.
package libv_pkg;
  typedef enum logic [1:0] {
    OpPushFront = 2'b00,
    OpPopFront  = 2'b01,
    OpPushBack  = 2'b10,
    OpPopBack   = 2'b11
  } deque_op_t;
endpackage

module libv_deque #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_vld,
  input  libv_pkg::deque_op_t      cmd_op,
  input  logic [W-1:0]             cmd_dat,
  output logic                     cmd_rdy,
  output logic                     rsp_vld,
  output logic [W-1:0]             rsp_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(N+1)-1:0]   cnt
);
  import libv_pkg::*;

  localparam int unsigned PW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW   = $clog2(N + 1);
  localparam logic [PW-1:0] LAST = PW'(N - 1);
  localparam logic [CW-1:0] CAP  = CW'(N);

  // Pointer arithmetic modulo N with explicit wrap (N need not be a power of two)
  function automatic logic [PW-1:0] incr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] decr(input logic [PW-1:0] p);
    return (p == '0) ? LAST : p - PW'(1);
  endfunction

  logic [W-1:0]  mem [N];
  logic [PW-1:0] head, tail;
  logic [PW-1:0] head_nx, tail_nx;
  logic [CW-1:0] cnt_nx;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          is_push, fire, wr_en, rd_en;

  // Acceptance and next-state computation
  always_comb begin
    head_nx = head;
    tail_nx = tail;
    cnt_nx  = cnt;
    wr_idx  = tail;
    rd_idx  = head;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    is_push = (cmd_op == OpPushFront) || (cmd_op == OpPushBack);
    cmd_rdy = is_push ? !full : !empty;
    fire    = cmd_vld && cmd_rdy;
    if (fire) begin
      case (cmd_op)
        OpPushBack: begin
          wr_en   = 1'b1;
          wr_idx  = tail;
          tail_nx = incr(tail);
          cnt_nx  = cnt + CW'(1);
        end
        OpPushFront: begin
          wr_en   = 1'b1;
          wr_idx  = decr(head);
          head_nx = decr(head);
          cnt_nx  = cnt + CW'(1);
        end
        OpPopFront: begin
          rd_en   = 1'b1;
          rd_idx  = head;
          head_nx = incr(head);
          cnt_nx  = cnt - CW'(1);
        end
        OpPopBack: begin
          rd_en   = 1'b1;
          rd_idx  = decr(tail);
          tail_nx = decr(tail);
          cnt_nx  = cnt - CW'(1);
        end
      endcase
    end
  end

  // Pointers, status and response; an in-flight response is dropped on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
      rsp_vld <= 1'b0;
      rsp_dat <= '0;
    end else begin
      head    <= head_nx;
      tail    <= tail_nx;
      cnt     <= cnt_nx;
      empty   <= (cnt_nx == '0);
      full    <= (cnt_nx == CAP);
      rsp_vld <= rd_en;
      if (rd_en) rsp_dat <= mem[rd_idx];
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= cmd_dat;
  end

endmodule
